// File: rtl/cruise_sequencer.sv
// Cruise-control sequencer: owns the desired speed and drives an external registered
// speed ALU through a request/wait handshake, turning its compare flags into throttle commands.
module cruise_sequencer #(
   parameter logic [7:0] MAX_SPEED = 8'd200,
   parameter logic [7:0] MIN_SPEED = 8'd30,
   parameter logic [7:0] STEP      = 8'd5
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       on_off,
   input  logic       set,
   input  logic       accel,
   input  logic       decel,
   input  logic       brake,
   input  logic [7:0] c_speed,
   input  logic [7:0] alu_speed,
   input  logic       alu_l,
   input  logic       alu_eq,
   input  logic       alu_g,
   output logic [1:0] mode,
   output logic [7:0] d_speed,
   output logic       active,
   output logic       throttle_up,
   output logic       throttle_down
);

   typedef enum logic [3:0] {
      S_OFF,
      S_ARMED,
      S_HOLD,
      S_INC_REQ,
      S_INC_WAIT,
      S_DEC_REQ,
      S_DEC_WAIT,
      S_CMP_REQ,
      S_CMP_WAIT
   } state_t;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_CMP  = 2'b01,
      MODE_ADD  = 2'b10,
      MODE_SUB  = 2'b11
   } mode_t;

   // Stepping only from inside these limits keeps d_speed in range without ALU wrap.
   localparam logic [7:0] INC_LIMIT = MAX_SPEED - STEP;
   localparam logic [7:0] DEC_LIMIT = MIN_SPEED + STEP;

   state_t     r_state;
   mode_t      r_mode;
   logic [7:0] r_d_speed;
   logic       r_active;
   logic       r_throttle_up;
   logic       r_throttle_down;

   logic w_busy;
   logic w_set_ok;
   logic w_inc_ok;
   logic w_dec_ok;
   logic w_up_next;
   logic w_down_next;

   assign w_busy   = (r_state != S_OFF) && (r_state != S_ARMED);
   assign w_set_ok = set && (c_speed >= MIN_SPEED) && (c_speed <= MAX_SPEED);
   assign w_inc_ok = accel && (r_d_speed <= INC_LIMIT);
   assign w_dec_ok = decel && (r_d_speed >= DEC_LIMIT);

   // Flags are qualified against each other so the two actuators can never both fire.
   assign w_up_next   = alu_l && !alu_eq && !alu_g;
   assign w_down_next = alu_g && !alu_eq && !alu_l;

   // NOTE: state and every output are registered in one block with non-blocking
   // assignments, so all of them change together on the same clock edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= S_OFF;
         r_mode          <= MODE_PASS;
         r_d_speed       <= 8'd0;
         r_active        <= 1'b0;
         r_throttle_up   <= 1'b0;
         r_throttle_down <= 1'b0;
      end else if (on_off && (r_state != S_OFF)) begin
         r_state         <= S_OFF;
         r_mode          <= MODE_PASS;
         r_d_speed       <= 8'd0;
         r_active        <= 1'b0;
         r_throttle_up   <= 1'b0;
         r_throttle_down <= 1'b0;
      end else if (brake && w_busy) begin
         // Any in-flight ALU result is dropped; d_speed keeps its last committed value.
         r_state         <= S_ARMED;
         r_mode          <= MODE_PASS;
         r_active        <= 1'b0;
         r_throttle_up   <= 1'b0;
         r_throttle_down <= 1'b0;
      end else begin
         case (r_state)
            S_OFF: begin
               if (on_off) begin
                  r_state <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (w_set_ok) begin
                  r_state   <= S_HOLD;
                  r_d_speed <= c_speed;
                  r_active  <= 1'b1;
               end
            end
            S_HOLD: begin
               if (w_inc_ok) begin
                  r_state <= S_INC_REQ;
                  r_mode  <= MODE_ADD;
               end else if (w_dec_ok) begin
                  r_state <= S_DEC_REQ;
                  r_mode  <= MODE_SUB;
               end else begin
                  r_state <= S_CMP_REQ;
                  r_mode  <= MODE_CMP;
               end
            end
            S_INC_REQ: r_state <= S_INC_WAIT;
            S_DEC_REQ: r_state <= S_DEC_WAIT;
            S_CMP_REQ: r_state <= S_CMP_WAIT;
            S_INC_WAIT, S_DEC_WAIT: begin
               r_state   <= S_HOLD;
               r_mode    <= MODE_PASS;
               r_d_speed <= alu_speed;
            end
            S_CMP_WAIT: begin
               r_state         <= S_HOLD;
               r_mode          <= MODE_PASS;
               r_throttle_up   <= w_up_next;
               r_throttle_down <= w_down_next;
            end
            default: begin
               r_state         <= S_OFF;
               r_mode          <= MODE_PASS;
               r_d_speed       <= 8'd0;
               r_active        <= 1'b0;
               r_throttle_up   <= 1'b0;
               r_throttle_down <= 1'b0;
            end
         endcase
      end
   end

   assign mode          = r_mode;
   assign d_speed       = r_d_speed;
   assign active        = r_active;
   assign throttle_up   = r_throttle_up;
   assign throttle_down = r_throttle_down;

endmodule

// File: tb/tb_cruise_sequencer.sv
// Directed bench for cruise_sequencer with a registered speed-ALU model on the handshake side.
module tb_cruise_sequencer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       on_off, set, accel, decel, brake;
   logic [7:0] c_speed;
   logic [7:0] alu_speed;
   logic       alu_l, alu_eq, alu_g;
   logic [1:0] mode;
   logic [7:0] d_speed;
   logic       active, throttle_up, throttle_down;

   logic [12:0] obs;
   logic [12:0] exp_v;
   int          n_cmp = 0;
   int          n_bad = 0;

   assign obs = {mode, d_speed, active, throttle_up, throttle_down};

   always #5 clock = ~clock;

   cruise_sequencer dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .on_off       (on_off),
      .set          (set),
      .accel        (accel),
      .decel        (decel),
      .brake        (brake),
      .c_speed      (c_speed),
      .alu_speed    (alu_speed),
      .alu_l        (alu_l),
      .alu_eq       (alu_eq),
      .alu_g        (alu_g),
      .mode         (mode),
      .d_speed      (d_speed),
      .active       (active),
      .throttle_up  (throttle_up),
      .throttle_down(throttle_down)
   );

   // External ALU: registers its result from the opcode and d_speed it sees each cycle.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alu_speed <= 8'd0;
         alu_l     <= 1'b0;
         alu_eq    <= 1'b0;
         alu_g     <= 1'b0;
      end else begin
         case (mode)
            2'b00: alu_speed <= d_speed;
            2'b01: begin
               alu_l  <= (c_speed < d_speed);
               alu_eq <= (c_speed == d_speed);
               alu_g  <= (c_speed > d_speed);
            end
            2'b10: alu_speed <= d_speed + 8'd5;
            2'b11: alu_speed <= d_speed - 8'd5;
            default: ;
         endcase
      end
   end

   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         n_cmp++;
         if (throttle_up && throttle_down) begin
            n_bad++;
            $display("FAIL throttle_exclusive: got up=%b down=%b, want not both 1", throttle_up, throttle_down);
         end
      end
   end

   function automatic logic [12:0] ex(input logic [1:0] m, input logic [7:0] d,
                                      input logic a, input logic u, input logic dn);
      return {m, d, a, u, dn};
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_on_off;
      on_off = 1'b1;
      tick();
      on_off = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      {on_off, set, accel, decel, brake} = '0;
      c_speed = 8'd60;
      #12;
      n_cmp++;
      if (obs !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_hold: got %h want %h", obs, 13'd0);
      end
      @(negedge clock);
      reset_n = 1'b1;
      set = 1'b1;
      tick();
      set = 1'b0;
      n_cmp++;
      if (obs !== 13'd0) begin
         n_bad++;
         $display("FAIL off_ignores_set: got %h want %h", obs, 13'd0);
      end
   endtask

   task automatic test_engage;
      pulse_on_off();
      c_speed = 8'd29;
      set = 1'b1;
      tick();
      c_speed = 8'd201;
      tick();
      set = 1'b0;
      n_cmp++;
      if (obs !== 13'd0) begin
         n_bad++;
         $display("FAIL set_out_of_range: got %h want %h", obs, 13'd0);
      end
      c_speed = 8'd60;
      set = 1'b1;
      tick();
      set = 1'b0;
      exp_v = ex(2'b00, 8'd60, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL engage: got %h want %h", obs, exp_v);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         exp_v = ex((i % 3 == 2) ? 2'b00 : 2'b01, 8'd60, 1'b1, 1'b0, 1'b0);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL cmp_loop[%0d]: got %h want %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_accel_decel;
      accel = 1'b1;
      tick();
      accel = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_v = ex(2'b10, 8'd60, 1'b1, 1'b0, 1'b0);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL inc_mode[%0d]: got %h want %h", i, obs, exp_v);
         end
         if (i == 0) tick();
      end
      tick();
      exp_v = ex(2'b00, 8'd65, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL inc_result: got %h want %h", obs, exp_v);
      end
      // accel wins over decel when both are requested
      accel = 1'b1;
      decel = 1'b1;
      tick();
      {accel, decel} = '0;
      exp_v = ex(2'b10, 8'd65, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL accel_priority: got %h want %h", obs, exp_v);
      end
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         decel = 1'b1;
         tick();
         decel = 1'b0;
         tick();
         tick();
         exp_v = ex(2'b00, (i == 0) ? 8'd65 : 8'd60, 1'b1, 1'b0, 1'b0);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL dec_result[%0d]: got %h want %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_throttle;
      logic [7:0] speeds [3];
      logic [1:0] want [3];
      speeds = '{8'd50, 8'd60, 8'd75};
      want   = '{2'b10, 2'b00, 2'b01};
      for (int i = 0; i < 3; i++) begin
         c_speed = speeds[i];
         tick();
         tick();
         tick();
         exp_v = ex(2'b00, 8'd60, 1'b1, want[i][1], want[i][0]);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL throttle[c=%0d]: got %h want %h", speeds[i], obs, exp_v);
         end
      end
   endtask

   task automatic test_brake_dec_wait;
      decel = 1'b1;
      tick();
      decel = 1'b0;
      tick();
      exp_v = ex(2'b11, 8'd60, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL dec_wait: got %h want %h", obs, exp_v);
      end
      brake = 1'b1;
      tick();
      brake = 1'b0;
      exp_v = ex(2'b00, 8'd60, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL brake_abort: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_guard_max;
      c_speed = 8'd198;
      set = 1'b1;
      tick();
      set = 1'b0;
      accel = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         exp_v = ex((i % 3 == 2) ? 2'b00 : 2'b01, 8'd198, 1'b1, 1'b0, 1'b0);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL max_guard[%0d]: got %h want %h", i, obs, exp_v);
         end
      end
      decel = 1'b1;
      tick();
      {accel, decel} = '0;
      tick();
      tick();
      exp_v = ex(2'b00, 8'd193, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL accel_fallthrough: got %h want %h", obs, exp_v);
      end
      brake = 1'b1;
      tick();
      brake = 1'b0;
      c_speed = 8'd195;
      set = 1'b1;
      tick();
      set = 1'b0;
      accel = 1'b1;
      tick();
      accel = 1'b0;
      tick();
      tick();
      exp_v = ex(2'b00, 8'd200, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL max_edge_inc: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_guard_min;
      brake = 1'b1;
      tick();
      brake = 1'b0;
      c_speed = 8'd35;
      set = 1'b1;
      tick();
      set = 1'b0;
      decel = 1'b1;
      tick();
      decel = 1'b0;
      tick();
      tick();
      exp_v = ex(2'b00, 8'd30, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL min_edge_dec: got %h want %h", obs, exp_v);
      end
      decel = 1'b1;
      tick();
      decel = 1'b0;
      exp_v = ex(2'b01, 8'd30, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL min_guard: got %h want %h", obs, exp_v);
      end
      tick();
      tick();
      exp_v = ex(2'b00, 8'd30, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL min_compare: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_on_off_priority;
      tick();
      on_off = 1'b1;
      brake  = 1'b1;
      tick();
      {on_off, brake} = '0;
      n_cmp++;
      if (obs !== 13'd0) begin
         n_bad++;
         $display("FAIL on_off_over_brake: got %h want %h", obs, 13'd0);
      end
   endtask

   task automatic test_reset_mid;
      c_speed = 8'd60;
      pulse_on_off();
      set = 1'b1;
      tick();
      set = 1'b0;
      accel = 1'b1;
      tick();
      accel = 1'b0;
      exp_v = ex(2'b10, 8'd60, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL inc_req_pre_reset: got %h want %h", obs, exp_v);
      end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== 13'd0) begin
         n_bad++;
         $display("FAIL async_reset: got %h want %h", obs, 13'd0);
      end
      @(negedge clock);
      reset_n = 1'b1;
      set = 1'b1;
      tick();
      tick();
      set = 1'b0;
      n_cmp++;
      if (obs !== 13'd0) begin
         n_bad++;
         $display("FAIL post_reset_off: got %h want %h", obs, 13'd0);
      end
      pulse_on_off();
      set = 1'b1;
      tick();
      set = 1'b0;
      exp_v = ex(2'b00, 8'd60, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL reengage: got %h want %h", obs, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_engage();
      test_accel_decel();
      test_throttle();
      test_brake_dec_wait();
      test_guard_max();
      test_guard_min();
      test_on_off_priority();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
